// File: rtl/isl58x_dac_streamer.sv
// ISL58x laser DAC streamer: sample FIFO, divided DAC clock, power/RTZ control.
// Ports: clk/reset (async low); s_data/s_valid/s_ready upstream stream;
//   enable/rtz_mode controls; fifo_level, underrun, underrun_count status;
//   isl58x_CE/CLK/D/LOWP/RTZ registered DAC pins.
module isl58x_dac_streamer #(
   parameter int unsigned DATA_W       = 15,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned WAKE_PERIODS = 8,
   parameter logic [DATA_W-1:0] IDLE_CODE = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          enable,
   input  logic                          rtz_mode,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic [15:0]                   underrun_count,
   output logic                          isl58x_CE,
   output logic                          isl58x_CLK,
   output logic [DATA_W-1:0]             isl58x_D,
   output logic                          isl58x_LOWP,
   output logic                          isl58x_RTZ
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int WW = (WAKE_PERIODS > 2) ? $clog2(WAKE_PERIODS) : 1;

   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
   localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_PERIODS - 1);

   typedef enum logic [1:0] {
      SLEEP,
      WAKE,
      RUN,
      STOP
   } state_t;

   // ---------------- sample FIFO ----------------
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level;
   logic              alive;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // ---------------- control ----------------
   state_t            state;
   logic [DW-1:0]     div_cnt;
   logic [WW-1:0]     wake_cnt;
   logic              period_start;
   logic              period_end;
   logic              clk_hi;
   logic              to_sleep;

   logic              ce_q;
   logic              clk_q;
   logic [DATA_W-1:0] d_q;
   logic              lowp_q;
   logic              rtz_q;
   logic              urun_q;
   logic [15:0]       urun_cnt;

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);

   // alive keeps s_ready low until the first edge after reset release;
   // full comes from registered occupancy, so a pop can never make room
   // for a push in the same cycle.
   assign s_ready = alive & ~full;
   assign push    = s_valid & s_ready;

   assign period_start = (div_cnt == '0);
   assign period_end   = (div_cnt == DIV_LAST);
   assign clk_hi       = (div_cnt >= DIV_HALF);

   // No fall-through: level is registered, so a sample written this cycle
   // is only seen at a later period start.
   assign pop = (state == RUN) & period_start & ~empty;

   // A period always runs to completion before dropping to SLEEP.
   assign to_sleep = period_end &
                     ((state == STOP) |
                      (((state == WAKE) | (state == RUN)) & ~enable));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         alive <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= SLEEP;
         div_cnt  <= '0;
         wake_cnt <= '0;
         ce_q     <= 1'b0;
         clk_q    <= 1'b0;
         d_q      <= IDLE_CODE;
         lowp_q   <= 1'b1;
         rtz_q    <= 1'b0;
         urun_q   <= 1'b0;
         urun_cnt <= '0;
      end else begin
         urun_q <= 1'b0;
         if (state == SLEEP) begin
            // Outputs already hold their sleep values; only RTZ tracks.
            rtz_q    <= rtz_mode;
            wake_cnt <= '0;
            if (enable) begin
               state  <= WAKE;
               ce_q   <= 1'b1;
               lowp_q <= 1'b0;
            end
         end else if (to_sleep) begin
            state   <= SLEEP;
            div_cnt <= '0;
            clk_q   <= 1'b0;
            ce_q    <= 1'b0;
            lowp_q  <= 1'b1;
            d_q     <= IDLE_CODE;
         end else begin
            div_cnt <= period_end ? '0 : div_cnt + 1'b1;
            // Registered from the current count: the rise lands mid-eye,
            // half a period after D changes.
            clk_q   <= clk_hi;
            unique case (state)
               WAKE: begin
                  if (period_end) begin
                     wake_cnt <= wake_cnt + 1'b1;
                  end
                  if (!enable) begin
                     state <= STOP;
                  end else if (period_end && wake_cnt == WAKE_LAST) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (period_start) begin
                     if (!empty) begin
                        d_q <= mem[rd_ptr];
                     end else begin
                        d_q    <= IDLE_CODE;
                        urun_q <= 1'b1;
                        if (urun_cnt != 16'hFFFF) begin
                           urun_cnt <= urun_cnt + 1'b1;
                        end
                     end
                  end
                  if (!enable) begin
                     state <= STOP;
                  end
               end
               default: begin
                  // STOP: finish the current period, no new pops.
                  state <= state;
               end
            endcase
         end
      end
   end

   assign fifo_level     = level;
   assign underrun       = urun_q;
   assign underrun_count = urun_cnt;
   assign isl58x_CE      = ce_q;
   assign isl58x_CLK     = clk_q;
   assign isl58x_D       = d_q;
   assign isl58x_LOWP    = lowp_q;
   assign isl58x_RTZ     = rtz_q;

endmodule

// File: tb/tb_isl58x_dac_streamer.sv
// Bench for isl58x_dac_streamer: random samples, queue-based reference of the
// DAC sample stream, monitor compares on every isl58x_CLK rise.
module tb_isl58x_dac_streamer;

   localparam int DW    = 15;
   localparam int DEPTH = 16;
   localparam int DIV   = 4;
   localparam int WAKE  = 8;
   localparam logic [DW-1:0] IDLE = '0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          enable = 1'b0;
   logic          rtz_mode = 1'b0;
   logic [4:0]    fifo_level;
   logic          underrun;
   logic [15:0]   underrun_count;
   logic          isl58x_CE;
   logic          isl58x_CLK;
   logic [DW-1:0] isl58x_D;
   logic          isl58x_LOWP;
   logic          isl58x_RTZ;

   isl58x_dac_streamer #(
      .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(DIV),
      .WAKE_PERIODS(WAKE), .IDLE_CODE(IDLE)
   ) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .enable(enable), .rtz_mode(rtz_mode),
      .fifo_level(fifo_level), .underrun(underrun),
      .underrun_count(underrun_count),
      .isl58x_CE(isl58x_CE), .isl58x_CLK(isl58x_CLK), .isl58x_D(isl58x_D),
      .isl58x_LOWP(isl58x_LOWP), .isl58x_RTZ(isl58x_RTZ)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference: expected DAC stream = WAKE idle codes after each enable,
   // then every accepted sample in order, then idle codes with underruns.
   logic [DW-1:0] expq[$];
   int  exp_wake = 0;
   int  exp_ucnt = 0;
   bit  mon_en = 1'b0;
   logic prev_clk = 1'b0;
   int  pulses = 0;
   int  total_pulses = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [DW-1:0] e;
      int u;
      if (mon_en) begin
         if (underrun) begin
            pulses++;
            total_pulses++;
         end
         if (isl58x_CLK && !prev_clk) begin
            if (exp_wake > 0) begin
               e = IDLE; u = 0; exp_wake--;
            end else if (expq.size() > 0) begin
               e = expq.pop_front(); u = 0;
            end else begin
               e = IDLE; u = 1;
               if (exp_ucnt < 32'hFFFF) exp_ucnt++;
            end
            check("sample", 32'(isl58x_D), 32'(e));
            check("underrun_pulse", pulses, u);
            check("underrun_count", 32'(underrun_count), exp_ucnt);
            pulses = 0;
         end
      end
      prev_clk = isl58x_CLK;
   end

   // Called at a negedge; returns at a negedge after the transfer edge.
   task automatic push_one(input logic [DW-1:0] v);
      bit ok;
      ok = 1'b0;
      s_data = v;
      s_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            expq.push_back(v);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      check("push_accept", 32'(ok), 1);
   endtask

   task automatic start_stream();
      enable = 1'b1;
      exp_wake = WAKE;
   endtask

   // Drop enable in the div_cnt==1 cycle (just after CLK falls).
   task automatic stop_at_div1();
      logic last;
      int n;
      last = isl58x_CLK;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (last && !isl58x_CLK) break;
         last = isl58x_CLK;
      end
      check("stop_sync_found", 32'(n < 60), 1);
      enable = 1'b0;
      @(negedge clk);
      check("stop_ce_held", 32'(isl58x_CE), 1);
      @(negedge clk);
      check("stop_last_clk_high", 32'(isl58x_CLK), 1);
      @(negedge clk);
      check("sleep_ce", 32'(isl58x_CE), 0);
      check("sleep_lowp", 32'(isl58x_LOWP), 1);
      check("sleep_clk", 32'(isl58x_CLK), 0);
      check("sleep_d", 32'(isl58x_D), 32'(IDLE));
      check("retained_level", 32'(fifo_level), expq.size());
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce"}, 32'(isl58x_CE), 0);
      check({tag, "_clk"}, 32'(isl58x_CLK), 0);
      check({tag, "_d"}, 32'(isl58x_D), 32'(IDLE));
      check({tag, "_lowp"}, 32'(isl58x_LOWP), 1);
      check({tag, "_rtz"}, 32'(isl58x_RTZ), 0);
      check({tag, "_underrun"}, 32'(underrun), 0);
      check({tag, "_count"}, 32'(underrun_count), 0);
      check({tag, "_level"}, 32'(fifo_level), 0);
      check({tag, "_ready"}, 32'(s_ready), 0);
   endtask

   initial begin
      int n;
      int p0;
      logic [DW-1:0] v17;

      // Power-on reset
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b1;
      @(negedge clk);
      check("por_ready_after_release", 32'(s_ready), 1);
      mon_en = 1'b1;

      // Pre-filled 1..4, wake latency, then underrun
      for (int i = 1; i <= 4; i++) push_one(DW'(i));
      check("prefill_level", 32'(fifo_level), 4);
      start_stream();
      n = 0;
      while (isl58x_D == IDLE && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("wake_ce", 32'(isl58x_CE), 1);
            check("wake_lowp", 32'(isl58x_LOWP), 0);
         end
      end
      check("first_sample_latency", n, 1 + WAKE * DIV + 1);
      check("first_sample", 32'(isl58x_D), 1);
      n = 0;
      while (!underrun && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("underrun_seen", 32'(underrun), 1);
      check("underrun_first_count", 32'(underrun_count), 1);
      stop_at_div1();

      // Fill to full; 17th waits for the first RUN pop
      for (int i = 0; i < DEPTH; i++) push_one(DW'($urandom));
      check("full_level", 32'(fifo_level), DEPTH);
      check("full_not_ready", 32'(s_ready), 0);
      v17 = DW'($urandom);
      s_data = v17;
      s_valid = 1'b1;
      start_stream();
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_after_first_pop", n, 1 + WAKE * DIV + 1);
      check("level_after_first_pop", 32'(fifo_level), DEPTH - 1);
      expq.push_back(v17);
      @(negedge clk);
      s_valid = 1'b0;

      // Random pushes while streaming; level>=2 keeps the FIFO non-empty
      for (int c = 0; c < 80; c++) begin
         s_valid = (fifo_level >= 2) && ($urandom_range(0, 1) == 1);
         s_data = DW'($urandom);
         if (s_valid && s_ready) expq.push_back(s_data);
         @(negedge clk);
      end
      s_valid = 1'b0;
      stop_at_div1();

      // RTZ latched only in SLEEP; retained samples stream after wake
      rtz_mode = 1'b1;
      @(negedge clk);
      check("rtz_follow_sleep", 32'(isl58x_RTZ), 1);
      start_stream();
      repeat (40) @(negedge clk);
      rtz_mode = 1'b0;
      repeat (6) @(negedge clk);
      check("rtz_hold_run", 32'(isl58x_RTZ), 1);
      n = 0;
      while (!underrun && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_underrun_seen", 32'(underrun), 1);
      stop_at_div1();
      @(negedge clk);
      check("rtz_follow_sleep_0", 32'(isl58x_RTZ), 0);

      // Counter saturation
      dut.urun_cnt = 16'hFFFE;
      exp_ucnt = 32'hFFFE;
      p0 = total_pulses;
      start_stream();
      repeat (1 + WAKE * DIV + 6 * DIV) @(negedge clk);
      check("sat_count", 32'(underrun_count), 32'hFFFF);
      check("sat_pulses", total_pulses - p0, 6);
      stop_at_div1();

      // Reset mid-RUN with 5 samples queued
      rtz_mode = 1'b1;
      @(negedge clk);
      rtz_mode = 1'b0;
      for (int i = 0; i < 7; i++) push_one(DW'($urandom));
      start_stream();
      n = 0;
      while (fifo_level != 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("midrun_level5", 32'(fifo_level), 5);
      @(negedge clk);
      mon_en = 1'b0;
      enable = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrun_rst");
      expq.delete();
      exp_wake = 0;
      exp_ucnt = 0;
      pulses = 0;
      @(negedge clk);
      check_reset_outputs("midrun_rst_hold");
      reset = 1'b1;
      @(negedge clk);
      check("midrun_ready_after_release", 32'(s_ready), 1);
      check("midrun_level_after_release", 32'(fifo_level), 0);
      check("midrun_ce_after_release", 32'(isl58x_CE), 0);
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
